// File: rtl/cf_spi_master_fifo.sv
// SPI master with TX/RX byte FIFOs behind a 4-register host I/O window.
// Optional level interrupt output enabled by defining NHCI_SPI_IRQ_EN.
module cf_spi_master_fifo #(
    parameter int unsigned NCS     = 1,
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned DIV_W   = 8
) (
    input  logic           clk_26,
    input  logic           RESET,
    input  logic [1:0]     io_addr,
    input  logic [7:0]     io_wdata,
    input  logic           io_wr,
    input  logic           io_rd,
    output logic [7:0]     io_rdata,
    output logic           busy,
    output logic [NCS-1:0] SS,
    output logic           SCLK,
    output logic           MOSI,
    input  logic           MISO,
    output logic           INT
);

    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FullCnt = (FIFO_AW + 1)'(Depth);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;
    state_e state_q, state_d;

    logic [7:0]         tx_mem [Depth];
    logic [7:0]         rx_mem [Depth];
    logic [FIFO_AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [FIFO_AW:0]   tx_cnt_q, rx_cnt_q;
    logic [7:0]         ctrl_q;
    logic [DIV_W-1:0]   div_q, div_snap_q, div_cnt_q;
    logic               tx_ovf_q, rx_ovf_q, rx_unf_q;
    logic               cpol_q, cpha_q, lsb_q, discard_q, sclk_q, mosi_q;
    logic [2:0]         cs_idx_q, cs_sel;
    logic [3:0]         edge_q;
    logic [7:0]         tx_sr_q, rx_sr_q, tx_byte, status, rdata_d;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic wr_data, rd_data, rd_stat;
    logic tx_push, tx_pop, tx_drop, rx_push_req, rx_push, rx_pop, rx_drop;
    logic half_end, sample_edge;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FullCnt);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FullCnt);
    assign wr_data  = io_wr && (io_addr == 2'd0);
    assign rd_data  = io_rd && (io_addr == 2'd0);
    assign rd_stat  = io_rd && (io_addr == 2'd1);

    // A push into a full FIFO is accepted only when the same cycle frees a slot.
    assign tx_pop      = (state_q == StLoad);
    assign tx_push     = wr_data && (!tx_full || tx_pop);
    assign tx_drop     = wr_data && !tx_push;
    assign rx_pop      = rd_data && !rx_empty;
    assign rx_push_req = (state_q == StDone) && !discard_q;
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign rx_drop     = rx_push_req && !rx_push;

    assign tx_byte     = tx_mem[tx_rp_q];
    assign half_end    = (div_cnt_q == div_snap_q);
    // Even edge index is the leading SCLK edge; CPHA picks which edge samples.
    assign sample_edge = ~edge_q[0] ^ cpha_q;
    assign status = {rx_unf_q, rx_ovf_q, tx_ovf_q, busy, rx_full, rx_empty, tx_full, tx_empty};

    always_ff @(posedge clk_26) begin
        if (RESET) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!tx_empty) state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: if (half_end && edge_q == 4'd15) state_d = StDone;
            StDone:  state_d = tx_empty ? StIdle : StLoad;
            default: state_d = StIdle;
        endcase
    end

    // Chip-select index follows CTRL until the byte snapshot is taken; cs_en is always live.
    always_comb begin
        busy   = (state_q != StIdle);
        SCLK   = sclk_q;
        MOSI   = mosi_q;
        cs_sel = (state_q == StIdle || state_q == StLoad) ? ctrl_q[2:0] : cs_idx_q;
        SS     = '1;
        for (int i = 0; i < NCS; i++) begin
            if (ctrl_q[3] && cs_sel == 3'(i)) SS[i] = 1'b0;
        end
    end

    always_comb begin
        rdata_d = '0;
        unique case (io_addr)
            2'd0: rdata_d = rx_empty ? 8'h00 : rx_mem[rx_rp_q];
            2'd1: rdata_d = status;
            2'd2: rdata_d = ctrl_q;
            2'd3: rdata_d = 8'(div_q);
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_26) begin
        if (tx_push) tx_mem[tx_wp_q] <= io_wdata;
        if (rx_push) rx_mem[rx_wp_q] <= rx_sr_q;
    end

    always_ff @(posedge clk_26) begin
        if (RESET) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            ctrl_q   <= '0;
            div_q    <= '0;
            io_rdata <= '0;
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
            tx_cnt_q <= tx_cnt_q + (FIFO_AW + 1)'(tx_push) - (FIFO_AW + 1)'(tx_pop);
            rx_cnt_q <= rx_cnt_q + (FIFO_AW + 1)'(rx_push) - (FIFO_AW + 1)'(rx_pop);
            if (io_wr && io_addr == 2'd2) ctrl_q <= io_wdata;
            if (io_wr && io_addr == 2'd3) div_q  <= DIV_W'(io_wdata);
            if (io_rd) io_rdata <= rdata_d;
            // A new event in the clearing cycle wins over the clear.
            tx_ovf_q <= (tx_ovf_q & ~rd_stat) | tx_drop;
            rx_ovf_q <= (rx_ovf_q & ~rd_stat) | rx_drop;
            rx_unf_q <= (rx_unf_q & ~rd_stat) | (rd_data && rx_empty);
        end
    end

    always_ff @(posedge clk_26) begin
        if (RESET) begin
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            discard_q  <= 1'b0;
            div_snap_q <= '0;
            div_cnt_q  <= '0;
            cs_idx_q   <= '0;
            edge_q     <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: sclk_q <= ctrl_q[4];
                StLoad: begin
                    cpol_q     <= ctrl_q[4];
                    cpha_q     <= ctrl_q[5];
                    lsb_q      <= ctrl_q[6];
                    discard_q  <= ctrl_q[7];
                    div_snap_q <= div_q;
                    cs_idx_q   <= ctrl_q[2:0];
                    div_cnt_q  <= '0;
                    edge_q     <= '0;
                    rx_sr_q    <= '0;
                    sclk_q     <= ctrl_q[4];
                    if (!ctrl_q[5]) begin
                        mosi_q  <= ctrl_q[6] ? tx_byte[0] : tx_byte[7];
                        tx_sr_q <= ctrl_q[6] ? {1'b0, tx_byte[7:1]} : {tx_byte[6:0], 1'b0};
                    end else begin
                        tx_sr_q <= tx_byte;
                    end
                end
                StShift: begin
                    if (half_end) begin
                        div_cnt_q <= '0;
                        edge_q    <= edge_q + 4'd1;
                        sclk_q    <= ~sclk_q;
                        if (sample_edge) begin
                            rx_sr_q <= lsb_q ? {MISO, rx_sr_q[7:1]} : {rx_sr_q[6:0], MISO};
                        end else begin
                            mosi_q  <= lsb_q ? tx_sr_q[0] : tx_sr_q[7];
                            tx_sr_q <= lsb_q ? {1'b0, tx_sr_q[7:1]} : {tx_sr_q[6:0], 1'b0};
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                StDone: sclk_q <= cpol_q;
                default: sclk_q <= cpol_q;
            endcase
        end
    end

`ifdef NHCI_SPI_IRQ_EN
    logic int_q;
    always_ff @(posedge clk_26) begin
        if (RESET) int_q <= 1'b0;
        else       int_q <= (tx_empty & ~busy) | rx_full | tx_ovf_q | rx_ovf_q | rx_unf_q;
    end
    assign INT = int_q;
`else
    assign INT = 1'b0;
`endif

endmodule

// File: tb/tb_cf_spi_master_fifo.sv
// Directed bench for cf_spi_master_fifo (default parameters, MISO looped back to MOSI).
module tb_cf_spi_master_fifo;

    logic       clk_26 = 1'b0;
    logic       RESET;
    logic [1:0] io_addr;
    logic [7:0] io_wdata;
    logic       io_wr, io_rd;
    logic [7:0] io_rdata;
    logic       busy;
    logic [0:0] SS;
    logic       SCLK, MOSI, MISO, INT;

    int vec_cnt = 0;
    int err_cnt = 0;

    assign MISO = MOSI;

    always #5 clk_26 = ~clk_26;

    cf_spi_master_fifo #(
        .NCS     (1),
        .FIFO_AW (3),
        .DIV_W   (8)
    ) u_dut (
        .clk_26   (clk_26),
        .RESET    (RESET),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_wr    (io_wr),
        .io_rd    (io_rd),
        .io_rdata (io_rdata),
        .busy     (busy),
        .SS       (SS),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .INT      (INT)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reg_wr(input logic [1:0] addr, input logic [7:0] data);
        @(negedge clk_26);
        io_addr  = addr;
        io_wdata = data;
        io_wr    = 1'b1;
        @(negedge clk_26);
        io_wr    = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] addr, output logic [7:0] data);
        @(negedge clk_26);
        io_addr = addr;
        io_rd   = 1'b1;
        @(negedge clk_26);
        io_rd   = 1'b0;
        data    = io_rdata;
    endtask

    // Watch a window of cycles: SCLK rising edges, MOSI at the first SCLK edge, SS low while busy.
    task automatic watch(input int cycles, output int rises, output logic first_mosi,
                         output logic ss_low);
        logic prev, seen;
        rises      = 0;
        first_mosi = 1'b0;
        ss_low     = 1'b1;
        seen       = 1'b0;
        prev       = SCLK;
        repeat (cycles) begin
            @(negedge clk_26);
            if (SCLK !== prev && !seen) begin
                first_mosi = MOSI;
                seen       = 1'b1;
            end
            if (SCLK && !prev) rises++;
            if (busy && SS[0] !== 1'b0) ss_low = 1'b0;
            prev = SCLK;
        end
    endtask

    logic [7:0] rd;
    int         rises;
    logic       fm, ssl;

    initial begin
        RESET    = 1'b1;
        io_addr  = 2'd0;
        io_wdata = 8'h00;
        io_wr    = 1'b0;
        io_rd    = 1'b0;
        repeat (3) @(negedge clk_26);
        RESET = 1'b0;

        // Reset state
        check_eq("rst_ss", 32'(SS), 32'h1);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_int", 32'(INT), 32'h0);
        check_eq("rst_sclk", 32'(SCLK), 32'h0);
        check_eq("rst_mosi", 32'(MOSI), 32'h0);
        check_eq("rst_rdata", 32'(io_rdata), 32'h0);
        reg_rd(2'd1, rd);
        check_eq("rst_status", 32'(rd), 32'h05);
        reg_wr(2'd3, 8'h2A);
        reg_rd(2'd3, rd);
        check_eq("div_readback", 32'(rd), 32'h2A);

        // Mode 0, MSB first, loopback of 0xA5
        reg_wr(2'd2, 8'h08);
        reg_wr(2'd3, 8'h00);
        check_eq("cs_asserted", 32'(SS), 32'h0);
        reg_wr(2'd0, 8'hA5);
        watch(40, rises, fm, ssl);
        check_eq("m0_sclk_rises", 32'(rises), 32'd8);
        check_eq("m0_first_mosi", 32'(fm), 32'h1);
        check_eq("m0_ss_low", 32'(ssl), 32'h1);
        check_eq("m0_busy_done", 32'(busy), 32'h0);
        check_eq("m0_sclk_idle", 32'(SCLK), 32'h0);
        reg_rd(2'd0, rd);
        check_eq("m0_rx", 32'(rd), 32'hA5);
        reg_rd(2'd1, rd);
        check_eq("m0_status", 32'(rd), 32'h05);

        // CPOL=1, CPHA=1, LSB first, loopback of 0x01
        reg_wr(2'd2, 8'h78);
        reg_wr(2'd3, 8'h00);
        check_eq("m3_sclk_idle_hi", 32'(SCLK), 32'h1);
        reg_rd(2'd2, rd);
        check_eq("ctrl_readback", 32'(rd), 32'h78);
        reg_wr(2'd0, 8'h01);
        watch(40, rises, fm, ssl);
        check_eq("m3_first_mosi", 32'(fm), 32'h1);
        check_eq("m3_sclk_rises", 32'(rises), 32'd8);
        check_eq("m3_sclk_end_hi", 32'(SCLK), 32'h1);
        reg_rd(2'd0, rd);
        check_eq("m3_rx", 32'(rd), 32'h01);

        // RX overflow: nine bytes with nothing read, the ninth is lost
        reg_wr(2'd2, 8'h08);
        for (int i = 0; i < 9; i++) reg_wr(2'd0, 8'(8'h10 + i));
        repeat (250) @(negedge clk_26);
        reg_rd(2'd1, rd);
        check_eq("rxovf_status", 32'(rd), 32'h49);
        reg_rd(2'd0, rd);
        check_eq("rxovf_first", 32'(rd), 32'h10);
        for (int i = 1; i < 7; i++) reg_rd(2'd0, rd);
        reg_rd(2'd0, rd);
        check_eq("rxovf_eighth", 32'(rd), 32'h17);
        reg_rd(2'd0, rd);
        check_eq("rx_underflow_data", 32'(rd), 32'h00);
        reg_rd(2'd1, rd);
        check_eq("rxunf_status", 32'(rd), 32'h85);
        reg_rd(2'd1, rd);
        check_eq("sticky_cleared", 32'(rd), 32'h05);

        // TX overflow at DIV=255: one byte already in the shifter, eight queued, rest dropped
        reg_wr(2'd3, 8'hFF);
        for (int i = 0; i < 10; i++) reg_wr(2'd0, 8'(8'h30 + i));
        reg_rd(2'd1, rd);
        check_eq("txovf_status", 32'(rd), 32'h36);
        reg_rd(2'd1, rd);
        check_eq("txovf_cleared", 32'(rd), 32'h16);

        // Abort mid-byte (around bit 4) with RESET
        repeat (2100) @(negedge clk_26);
        check_eq("abort_busy_before", 32'(busy), 32'h1);
        check_eq("abort_ss_before", 32'(SS), 32'h0);
        @(negedge clk_26);
        RESET = 1'b1;
        @(negedge clk_26);
        RESET = 1'b0;
        check_eq("abort_ss", 32'(SS), 32'h1);
        check_eq("abort_sclk", 32'(SCLK), 32'h0);
        check_eq("abort_busy", 32'(busy), 32'h0);
        check_eq("abort_int", 32'(INT), 32'h0);
        reg_rd(2'd1, rd);
        check_eq("abort_status", 32'(rd), 32'h05);
        reg_rd(2'd3, rd);
        check_eq("abort_div", 32'(rd), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
